// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl: Clause-22 MDIO master, MDC generation and 64-bit frame serialiser
module mdio_master_ctrl #(
    parameter int MDC_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        ta_err,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state, state_nx;
    logic [7:0]  div_cnt;
    logic        phase;
    logic [5:0]  bit_cnt;
    logic        is_write;
    logic [31:0] frame_lo;
    logic [15:0] shreg;
    logic        ta_err_q;
    logic        wrap, rise, last;
    assign wrap = div_cnt == 8'(MDC_DIV - 1);
    assign rise = state == SHIFT && wrap && !phase;
    assign last = state == SHIFT && wrap && phase && bit_cnt == 6'd63;
    // next state and outputs decoded from registered state; bits 0..31 are preamble ones
    always_comb begin
        state_nx  = (state == IDLE && cmd_valid) ? SHIFT : last ? DONE : (state == DONE) ? IDLE : state;
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        done      = state == DONE;
        rd_valid  = done && !is_write;
        ta_err    = rd_valid && ta_err_q;
        mdc       = phase;
        mdio_oe   = state == SHIFT && (is_write || bit_cnt < 6'd46);
        mdio_out  = (state == SHIFT && bit_cnt[5]) ? frame_lo[~bit_cnt[4:0]] : 1'b1;
    end
    // command capture, MDC divider, bit counter and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            is_write <= 1'b0;
            frame_lo <= '0;
            shreg    <= '0;
            ta_err_q <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                div_cnt  <= '0;
                phase    <= 1'b0;
                bit_cnt  <= '0;
                is_write <= cmd_write;
                frame_lo <= {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                             cmd_write ? {2'b10, cmd_wdata} : 18'h3_FFFF};
            end else if (state == SHIFT) begin
                div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
                if (wrap) phase <= !phase;
                if (wrap && phase) bit_cnt <= bit_cnt + 6'd1;
                if (rise && bit_cnt == 6'd47) ta_err_q <= mdio_in;
                if (rise && bit_cnt >= 6'd48) shreg <= {shreg[14:0], mdio_in};
                if (last && !is_write) rd_data <= shreg;
            end
        end
    end
endmodule

// File: doc/mdio_master_ctrl.md
# mdio_master_ctrl

- Clause-22 MDIO management master. Accepts one register read/write command at a time from the MAC host-register side.
- Generates MDC from the system clock and serialises the 64-bit management frame onto MDIO. Returns read data and a turnaround-error flag.
- Sits directly upstream of the PHY / MDIO slave model. The pad-level tristate buffer is external.

## Interface
- MDC_DIV, 10: clk cycles per MDC half-period; legal range 2..255. Bit period = 2*MDC_DIV clk cycles.
- clk  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_phy_addr  in  5  PHYAD.
- cmd_reg_addr  in  5  REGAD.
- cmd_wdata  in  16  write data.
- busy  out  1  high from acceptance through the DONE cycle.
- done  out  1  one-cycle pulse at end of every frame.
- rd_valid  out  1  one-cycle pulse, coincident with done, reads only.
- rd_data  out  16  read result; held until the next read completes.
- ta_err  out  1  coincident with done on reads; 1 if the sampled second TA bit was 1 (no PHY response).
- mdc  out  1  management clock.
- mdio_out  out  1  serial data out.
- mdio_oe  out  1  output enable for external tristate.
- mdio_in  in  1  serial data in from pad.

## Operation
- **Command capture.** On acceptance, register all cmd_* fields. Build a 64-bit frame:
  - 32 ones (preamble);
  - ST = 01;
  - OP = 01 (write) / 10 (read);
  - PHYAD[4:0] MSB first;
  - REGAD[4:0] MSB first;
  - TA = 10 (write) / driven-Z (read);
  - DATA[15:0] MSB first (wdata, or Z for read).
- **States:** IDLE, SHIFT, DONE.
  - IDLE → SHIFT on acceptance.
  - SHIFT → DONE after bit 63 completes its high phase.
  - DONE → IDLE unconditionally after 1 cycle.
- **Counters:**
  - div_cnt counts 0..MDC_DIV-1 and wraps.
  - phase toggles at each wrap; mdc = phase.
  - bit_cnt 0..63 increments at the end of each high phase.
- **Bit timing.** Each bit starts with mdc low. mdio_out/mdio_oe update on the first clk of the low phase. mdc rises MDC_DIV clks later, so setup = hold = MDC_DIV clks.
- **mdio_oe:**
  - 1 for bits 0..45.
  - Writes: 1 through bit 63.
  - Reads: 0 for bits 46..63, with mdio_out = 1 while released.
- **Read sampling.** Sample mdio_in on the clk where mdc transitions 0→1.
  - Bit 47 → ta_err_q (1 = error).
  - Bits 48..63 → shift register, MSB first.
- **DONE cycle:**
  - done = 1.
  - For reads: rd_data ← shift register, rd_valid = 1, ta_err = ta_err_q.
  - For writes: rd_data unchanged, ta_err = 0.
- **cmd_valid while busy:** ignored; not queued.
- **Idle outputs:** mdc = 0, mdio_oe = 0, mdio_out = 1.

## Timing
- **Reset values:** cmd_ready 1, busy 0, done 0, rd_valid 0, rd_data 0x0000, ta_err 0, mdc 0, mdio_out 1, mdio_oe 0. All counters 0, state IDLE.
- **Reset mid-frame:** the frame is abandoned at the next clk edge. All outputs take reset values on that edge; no done pulse.
- **Acceptance:** at edge T, busy = 1 and cmd_ready = 0 from T+1. Bit 0 is driven from T+1.
- **Frame length:** 128*MDC_DIV clk cycles in SHIFT, then 1 DONE cycle.
  - done asserted at T+1+128*MDC_DIV.
  - cmd_ready returns 1 the following cycle.
  - Minimum command-to-command spacing: 128*MDC_DIV + 2 clks.
- **Simultaneous events:**
  - Reset with cmd_valid: reset wins; command dropped.
  - cmd_valid during DONE: not accepted (cmd_ready = 0).
- **Clock stop:** mdc never glitches. Exactly 64 rising edges per frame; mdc is low on entry to DONE.

## Test plan
- **Write frame**, MDC_DIV=4, phy=5'h05, reg=5'h03, wdata=16'hA5C3.
  - Expect 64 mdc rising edges, each 8 clks apart.
  - Sampled bits equal 32×1, 01, 01, 00101, 00011, 10, 1010010111000011.
  - mdio_oe = 1 throughout; done after 513 clks; rd_valid = 0.
- **Read**, PHY model at addr 5 returning 16'h1234 on reg 2.
  - mdio_oe = 0 from bit 46.
  - rd_valid and done pulse together; rd_data = 16'h1234; ta_err = 0.
- **Read, no PHY:** mdio_in pulled to 1.
  - rd_data = 16'hFFFF; ta_err = 1 with rd_valid.
- **Back-to-back:** cmd_valid held high with two commands.
  - Second accepted exactly 1 cycle after done; cmd_valid pulses during busy are ignored (exactly 2 done pulses).
- **Reset mid-frame:** assert reset at bit 20 for 1 clk.
  - Next edge: mdc = 0, mdio_oe = 0, busy = 0, no done.
  - A fresh write then completes correctly.
- **MDC_DIV=2 boundary:** mdc period 4 clks, 50% duty; read of 16'h8001 returns correctly.
